sa_global_aged: RTL and testbench
=================================

# sa_global_aged

Parametrised global switch-allocation stage for one router output port. It selects among the local SA winners of `INPUT_NUM` input ports by QoS, with round-robin among equal QoS. A per-input age counter promotes starved requesters to top QoS. The winner is held in a registered output slot with a valid/ready handshake to VC assignment. Successor of the combinational global SA: adds aging, a decoupled output buffer and per-input grant feedback.

## Interface

- `INPUT_NUM`, 4: number of competing input ports (≥1).
- `VC_ID_W`, 3: VC id width.
- `QOS_W`, 4: QoS value width.
- `AGE_W`, 4: per-input age counter width.
- `AGE_THRESHOLD`, 8: age at which a request is promoted to max QoS; 0 disables aging; must be ≤ 2^AGE_W−1.
- `IDX_W`, derived: `INPUT_NUM>1 ? $clog2(INPUT_NUM) : 1`.

Ports:

- `clk` in 1: clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous active-high reset.
- `sa_local_vld_i` in INPUT_NUM: per-input request valid.
- `sa_local_vc_id_i` in INPUT_NUM*VC_ID_W: per-input VC id, packed, input 0 in the LSBs.
- `sa_local_qos_value_i` in INPUT_NUM*QOS_W: per-input QoS, packed.
- `sa_local_gnt_o` out INPUT_NUM: one-hot grant pulse, asserted in the capture cycle.
- `sa_global_vld_o` out 1: output slot holds a winner.
- `sa_global_rdy_i` in 1: downstream accepts the slot this cycle.
- `sa_global_inport_id_oh_o` out INPUT_NUM: winner input, one-hot.
- `sa_global_inport_idx_o` out IDX_W: winner input index.
- `sa_global_inport_vc_id_o` out VC_ID_W: winner VC id.
- `sa_global_qos_value_o` out QOS_W: winner's original (unpromoted) QoS.
- `sa_global_aged_o` out 1: winner was promoted by aging.

## Operation

- **Effective QoS.** `eff_qos[i] = aged[i] ? all-ones : qos[i]`, where `aged[i] = (AGE_THRESHOLD!=0) && age[i] >= AGE_THRESHOLD`.
- **Priority filter.** Input i is eligible iff `vld[i]` and `eff_qos[i] >= eff_qos[j]` for every valid j. Eligible inputs therefore all share the maximum effective QoS.
- **Round-robin.** Pointer `ptr` (IDX_W bits) names the highest-priority index. The winner is the first eligible input scanning ptr, ptr+1, … with wrap modulo INPUT_NUM. With INPUT_NUM=1 the winner is input 0 and `ptr` is constant 0.
- **Load condition.** `load = ~sa_global_vld_o | sa_global_rdy_i`.
- **Capture.** If `load` and any input is eligible:
  - the output registers take the winner's one-hot, index, VC id, original QoS and aged flag;
  - `sa_global_vld_o` is set to 1;
  - `sa_local_gnt_o` equals the winner one-hot;
  - `ptr` becomes `(winner_idx+1) mod INPUT_NUM`.
- **Drain.** If `load` and no input is valid, `sa_global_vld_o` is set to 0. The other output registers hold their values.
- **Stall.** If `~load`, outputs hold, `sa_local_gnt_o` is 0 and `ptr` holds.
- **Age counters.** For each i:
  - `~vld[i]` or `gnt[i]`: age := 0;
  - otherwise: age := min(age+1, 2^AGE_W−1), saturating.
  - Ages advance during stalls as well.
- **Input handshake.** The local stage drops or advances its request the cycle after seeing `gnt`. A request still asserted in that next cycle is treated as a new request.

## Timing

- Reset values: `sa_global_vld_o`=0, id_oh=0, idx=0, vc_id=0, qos=0, aged=0, all ages=0, `ptr`=0. `sa_local_gnt_o` is 0 during reset.
- Latency: a request at cycle t with `load` true appears on the outputs at t+1. `sa_local_gnt_o` is combinational in cycle t.
- Back-to-back: while `sa_global_rdy_i`=1 continuously, one winner is delivered per cycle (full throughput).
- Simultaneous valid & rdy with new requests: the old slot is consumed and the new winner captured in the same edge.
- Aging from request onset with output stalled: `aged` is true from cycle t+AGE_THRESHOLD.
- Reset mid-operation clears the slot and pointer immediately (asynchronous). The first capture happens on the first edge after deassertion.

## Structure

- Shared NoC package holds `QoS_Value_Width`, `VC_ID_NUM_MAX_W` and the typedefs `qos_t` and `vc_id_t`. Top-level parameter defaults are taken from these.
- One sub-module, `rr_arb_ptr`, contains the pointer register, the wrapped first-one search and the pointer update on `grant_en`. It outputs the one-hot and the index.
- Priority filter, age counters, one-hot output muxes and the output slot live in the top.

## Test plan

1. Reset, then all inputs idle: `sa_global_vld_o`=0 and `gnt`=0 for 10 cycles.
2. INPUT_NUM=4, all valid, QoS {2,5,5,1} (inputs 0..3), rdy=1 held: grants alternate 1,2,1,2. Inputs 0 and 3 age; with AGE_THRESHOLD=8, input 0 is promoted after its 8th unserved cycle and wins with `aged_o`=1, `qos_o`=2.
3. Equal QoS 3 on all four inputs, rdy=1: grant order 0,1,2,3,0. Idx output matches the one-hot every cycle.
4. Slot full, rdy=0 for 5 cycles: outputs stable, `gnt`=0, `ptr` unchanged. Setting rdy=1 captures the next winner on the same edge.
5. AGE_W=2, AGE_THRESHOLD=3, stall 10 cycles: age saturates at 3 with no wrap, and `aged` stays 1.
6. Reset asserted while `sa_global_vld_o`=1: all outputs go to 0 without waiting for a clock edge. After release, arbitration restarts from input 0.

Source files
------------

// File: rtl/sa_global_aged_pkg.sv
// rtl/sa_global_aged_pkg.sv - shared NoC widths, types and helpers for the global SA stage
package sa_global_aged_pkg;

  localparam int QoS_Value_Width = 4;
  localparam int VC_ID_NUM_MAX_W = 3;

  typedef logic [QoS_Value_Width-1:0] qos_t;
  typedef logic [VC_ID_NUM_MAX_W-1:0] vc_id_t;

  // Index width that stays legal for a single input.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_global_aged_if.sv
// rtl/sa_global_aged_if.sv - request/grant and output-slot bundle of the global SA stage
interface sa_global_aged_if
  import sa_global_aged_pkg::*;
#(
  parameter int INPUT_NUM = 4,
  parameter int VC_ID_W   = VC_ID_NUM_MAX_W,
  parameter int QOS_W     = QoS_Value_Width,
  parameter int IDX_W     = idx_width(INPUT_NUM)
);

  logic [INPUT_NUM-1:0]         sa_local_vld_i;
  logic [INPUT_NUM*VC_ID_W-1:0] sa_local_vc_id_i;
  logic [INPUT_NUM*QOS_W-1:0]   sa_local_qos_value_i;
  logic [INPUT_NUM-1:0]         sa_local_gnt_o;
  logic                         sa_global_vld_o;
  logic                         sa_global_rdy_i;
  logic [INPUT_NUM-1:0]         sa_global_inport_id_oh_o;
  logic [IDX_W-1:0]             sa_global_inport_idx_o;
  logic [VC_ID_W-1:0]           sa_global_inport_vc_id_o;
  logic [QOS_W-1:0]             sa_global_qos_value_o;
  logic                         sa_global_aged_o;

  // Requesters and VC-assignment side.
  modport master (
    output sa_local_vld_i, sa_local_vc_id_i, sa_local_qos_value_i, sa_global_rdy_i,
    input  sa_local_gnt_o, sa_global_vld_o, sa_global_inport_id_oh_o,
    input  sa_global_inport_idx_o, sa_global_inport_vc_id_o, sa_global_qos_value_o,
    input  sa_global_aged_o
  );

  // Allocator side.
  modport slave (
    input  sa_local_vld_i, sa_local_vc_id_i, sa_local_qos_value_i, sa_global_rdy_i,
    output sa_local_gnt_o, sa_global_vld_o, sa_global_inport_id_oh_o,
    output sa_global_inport_idx_o, sa_global_inport_vc_id_o, sa_global_qos_value_o,
    output sa_global_aged_o
  );

endinterface

// File: rtl/sa_global_aged_rr_arb_ptr.sv
// rtl/sa_global_aged_rr_arb_ptr.sv - pointer-based round-robin first-one search
module rr_arb_ptr #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_grant_en,
  output logic [N-1:0]     o_gnt_oh,
  output logic [IDX_W-1:0] o_gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic             w_found;

  // Scan ptr, ptr+1, ... with wrap and take the first requester.
  always_comb begin : p_search
    int               jj;
    logic [IDX_W-1:0] j_idx;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      jj = int'(r_ptr) + k;
      if (jj >= N) jj = jj - N;
      j_idx = IDX_W'(jj);
      if (!w_found && i_req[j_idx]) begin
        w_found          = 1'b1;
        o_gnt_oh[j_idx]  = 1'b1;
        o_gnt_idx        = j_idx;
      end
    end
  end

  // The input after the winner becomes highest priority next time.
  always_comb begin
    w_ptr_nxt = '0;
    if (int'(o_gnt_idx) != N - 1) w_ptr_nxt = o_gnt_idx + 1'b1;
  end

  // Pointer advances only on an actual capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else if (i_grant_en && w_found) r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/sa_global_aged.sv
// rtl/sa_global_aged.sv - QoS/round-robin global switch allocator with aging and output slot
module sa_global_aged
  import sa_global_aged_pkg::*;
#(
  parameter int INPUT_NUM     = 4,
  parameter int VC_ID_W       = VC_ID_NUM_MAX_W,
  parameter int QOS_W         = QoS_Value_Width,
  parameter int AGE_W         = 4,
  parameter int AGE_THRESHOLD = 8
) (
  input logic             clk,
  input logic             rst,
  sa_global_aged_if.slave bus
);

  localparam int               IDX_W   = idx_width(INPUT_NUM);
  localparam bit               AGE_EN  = (AGE_THRESHOLD != 0);
  localparam logic [AGE_W-1:0] AGE_THR = AGE_W'(AGE_THRESHOLD);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [QOS_W-1:0] QOS_MAX = '1;

  logic [AGE_W-1:0]     r_age [INPUT_NUM];
  logic                 r_vld;
  logic [INPUT_NUM-1:0] r_oh;
  logic [IDX_W-1:0]     r_idx;
  logic [VC_ID_W-1:0]   r_vc;
  logic [QOS_W-1:0]     r_qos;
  logic                 r_aged;

  logic [INPUT_NUM-1:0] w_aged;
  logic [QOS_W-1:0]     w_eff_qos [INPUT_NUM];
  logic [QOS_W-1:0]     w_max_qos;
  logic [INPUT_NUM-1:0] w_elig;
  logic [INPUT_NUM-1:0] w_win_oh;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_load;
  logic                 w_capture;
  logic [INPUT_NUM-1:0] w_gnt;
  logic [VC_ID_W-1:0]   w_sel_vc;
  logic [QOS_W-1:0]     w_sel_qos;
  logic                 w_sel_aged;

  // Promote starved inputs to top QoS and keep only those at the maximum.
  always_comb begin
    w_max_qos = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      w_aged[i]    = AGE_EN && (r_age[i] >= AGE_THR);
      w_eff_qos[i] = w_aged[i] ? QOS_MAX : bus.sa_local_qos_value_i[i*QOS_W +: QOS_W];
      if (bus.sa_local_vld_i[i] && (w_eff_qos[i] > w_max_qos)) w_max_qos = w_eff_qos[i];
    end
    for (int i = 0; i < INPUT_NUM; i++) begin
      w_elig[i] = bus.sa_local_vld_i[i] && (w_eff_qos[i] == w_max_qos);
    end
  end

  rr_arb_ptr #(
    .N     (INPUT_NUM),
    .IDX_W (IDX_W)
  ) u_rr_arb_ptr (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_elig),
    .i_grant_en (w_capture),
    .o_gnt_oh   (w_win_oh),
    .o_gnt_idx  (w_win_idx)
  );

  assign w_load    = ~r_vld | bus.sa_global_rdy_i;
  assign w_capture = w_load & (|w_elig);
  assign w_gnt     = (w_capture && !rst) ? w_win_oh : '0;

  // One-hot select of the winner's VC id, original QoS and aged flag.
  always_comb begin
    w_sel_vc   = '0;
    w_sel_qos  = '0;
    w_sel_aged = 1'b0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (w_win_oh[i]) begin
        w_sel_vc   = w_sel_vc  | bus.sa_local_vc_id_i[i*VC_ID_W +: VC_ID_W];
        w_sel_qos  = w_sel_qos | bus.sa_local_qos_value_i[i*QOS_W +: QOS_W];
        w_sel_aged = w_sel_aged | w_aged[i];
      end
    end
  end

  // Output slot: capture a winner, drain when idle, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_oh   <= '0;
      r_idx  <= '0;
      r_vc   <= '0;
      r_qos  <= '0;
      r_aged <= 1'b0;
    end else if (w_load) begin
      if (w_capture) begin
        r_vld  <= 1'b1;
        r_oh   <= w_win_oh;
        r_idx  <= w_win_idx;
        r_vc   <= w_sel_vc;
        r_qos  <= w_sel_qos;
        r_aged <= w_sel_aged;
      end else begin
        r_vld  <= 1'b0;
      end
    end
  end

  // Ages count unserved cycles of a pending request and saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INPUT_NUM; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < INPUT_NUM; i++) begin
        if (!bus.sa_local_vld_i[i] || w_gnt[i]) r_age[i] <= '0;
        else if (r_age[i] != AGE_MAX)           r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  assign bus.sa_local_gnt_o           = w_gnt;
  assign bus.sa_global_vld_o          = r_vld;
  assign bus.sa_global_inport_id_oh_o = r_oh;
  assign bus.sa_global_inport_idx_o   = r_idx;
  assign bus.sa_global_inport_vc_id_o = r_vc;
  assign bus.sa_global_qos_value_o    = r_qos;
  assign bus.sa_global_aged_o         = r_aged;

endmodule

// File: tb/tb_sa_global_aged.sv
// tb/tb_sa_global_aged.sv - scoreboard bench for the aged global switch allocator
module tb_sa_global_aged;
  import sa_global_aged_pkg::*;

  localparam int N   = 4;
  localparam int VW  = 3;
  localparam int QW  = 4;
  localparam int AW  = 4;
  localparam int THR = 8;
  localparam int IW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sa_global_aged_if #(.INPUT_NUM(N), .VC_ID_W(VW), .QOS_W(QW), .IDX_W(IW)) bus ();

  sa_global_aged #(
    .INPUT_NUM     (N),
    .VC_ID_W       (VW),
    .QOS_W         (QW),
    .AGE_W         (AW),
    .AGE_THRESHOLD (THR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [N-1:0]  oh;
    logic [IW-1:0] idx;
    logic [VW-1:0] vc;
    logic [QW-1:0] qos;
    logic          aged;
  } slot_t;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         vld;
  } cyc_t;

  slot_t slot_q[$];
  cyc_t  cyc_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  bit    mon_en = 1'b0;

  int m_age[N];
  int m_ptr;
  bit m_vld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_age[i] = 0;
    m_ptr = 0;
    m_vld = 1'b0;
    cyc_q.delete();
    slot_q.delete();
  endtask

  // Drive one cycle of inputs and predict the allocator's response to it.
  task automatic apply(input logic [N-1:0] v, input logic [N*VW-1:0] vc,
                       input logic [N*QW-1:0] q, input logic r);
    int    eff[N];
    int    mx;
    int    win;
    int    j;
    bit    load;
    cyc_t  c;
    slot_t s;
    bus.sa_local_vld_i       = v;
    bus.sa_local_vc_id_i     = vc;
    bus.sa_local_qos_value_i = q;
    bus.sa_global_rdy_i      = r;
    load = !m_vld || r;
    mx   = -1;
    for (int i = 0; i < N; i++) begin
      eff[i] = (m_age[i] >= THR) ? (1 << QW) - 1 : int'(q[i*QW +: QW]);
      if (v[i] && eff[i] > mx) mx = eff[i];
    end
    win = -1;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && v[j] && eff[j] == mx) win = j;
      end
    end
    c.vld = m_vld;
    c.gnt = '0;
    if (win >= 0) c.gnt[win] = 1'b1;
    cyc_q.push_back(c);
    if (win >= 0) begin
      s.oh       = '0;
      s.oh[win]  = 1'b1;
      s.idx      = IW'(win);
      s.vc       = vc[win*VW +: VW];
      s.qos      = q[win*QW +: QW];
      s.aged     = (m_age[win] >= THR);
      slot_q.push_back(s);
      m_vld = 1'b1;
      m_ptr = (win + 1) % N;
    end else if (load) begin
      m_vld = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (!v[i] || win == i) m_age[i] = 0;
      else if (m_age[i] < (1 << AW) - 1) m_age[i] = m_age[i] + 1;
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*VW-1:0] vc,
                       input logic [N*QW-1:0] q, input logic r);
    apply(v, vc, q, r);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.sa_local_vld_i       = '0;
    bus.sa_local_vc_id_i     = '0;
    bus.sa_local_qos_value_i = '0;
    bus.sa_global_rdy_i      = 1'b0;
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_vld",   bus.sa_global_vld_o, 0);
    check("rst_oh",    bus.sa_global_inport_id_oh_o, 0);
    check("rst_idx",   bus.sa_global_inport_idx_o, 0);
    check("rst_vc",    bus.sa_global_inport_vc_id_o, 0);
    check("rst_qos",   bus.sa_global_qos_value_o, 0);
    check("rst_aged",  bus.sa_global_aged_o, 0);
    check("rst_gnt",   bus.sa_local_gnt_o, 0);
    model_reset();
    set_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: compare per-cycle grant/valid and every accepted slot.
  always @(negedge clk) begin
    cyc_t  c;
    slot_t s;
    if (mon_en && !rst) begin
      if (cyc_q.size() == 0) begin
        check("cyc_queue_empty", 1, 0);
      end else begin
        c = cyc_q.pop_front();
        check("gnt", bus.sa_local_gnt_o, c.gnt);
        check("vld", bus.sa_global_vld_o, c.vld);
        if (bus.sa_global_vld_o && bus.sa_global_rdy_i) begin
          if (slot_q.size() == 0) begin
            check("slot_queue_empty", 1, 0);
          end else begin
            s = slot_q.pop_front();
            check("oh",   bus.sa_global_inport_id_oh_o, s.oh);
            check("idx",  bus.sa_global_inport_idx_o, s.idx);
            check("vc",   bus.sa_global_inport_vc_id_o, s.vc);
            check("qos",  bus.sa_global_qos_value_o, s.qos);
            check("aged", bus.sa_global_aged_o, s.aged);
          end
        end
      end
    end
  end

  logic [N*QW-1:0] q_mix;
  logic [N*QW-1:0] q_eq;
  logic [N*QW-1:0] q_rnd;

  initial begin
    q_mix = {4'd1, 4'd5, 4'd5, 4'd2};
    q_eq  = {4'd3, 4'd3, 4'd3, 4'd3};
    set_idle();
    model_reset();
    @(posedge clk);
    #1;
    check("init_vld", bus.sa_global_vld_o, 0);
    check("init_gnt", bus.sa_local_gnt_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Idle inputs: nothing granted, slot stays empty.
    for (int k = 0; k < 10; k++) cycle('0, (N*VW)'($urandom), (N*QW)'($urandom), k[0]);

    // Mixed QoS with aging promotion of input 0.
    for (int k = 0; k < 14; k++) cycle('1, (N*VW)'($urandom), q_mix, 1'b1);

    // Reset while the slot is full.
    do_reset();

    // Equal QoS round-robin from input 0.
    for (int k = 0; k < 6; k++) cycle('1, (N*VW)'($urandom), q_eq, 1'b1);

    // Stall with slot full, then release.
    for (int k = 0; k < 5; k++) cycle('1, (N*VW)'($urandom), q_eq, 1'b0);
    for (int k = 0; k < 3; k++) cycle('1, (N*VW)'($urandom), q_eq, 1'b1);

    // Long stall: ages saturate without wrapping, then drain aged winners.
    for (int k = 0; k < 20; k++) cycle('1, (N*VW)'($urandom), q_mix, 1'b0);
    for (int k = 0; k < 6; k++) cycle('1, (N*VW)'($urandom), q_mix, 1'b1);

    // Randomised traffic, mostly busy inputs so aging kicks in.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) q_rnd[i*QW +: QW] = QW'($urandom_range(0, 3));
      cycle(N'($urandom | $urandom), (N*VW)'($urandom), q_rnd,
            1'($urandom_range(0, 9) < 7));
    end

    // Drain.
    for (int k = 0; k < 3; k++) cycle('0, '0, '0, 1'b1);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
